pad_hit_capture: RTL

Sits directly downstream of the pad-mode data checker. It consumes the checker's qualified hit frames (116 bits: BCID[115:104], pad hits[103:0]) plus the link status. On an arm request it captures a programmable number of hit frames into a small FIFO that slow-control or ILA readout drains. It also keeps a free-running hit-frame counter and a link-drop counter.

---
 rtl/pad_pkg.sv | 17 +
 rtl/pad_sync_fifo.sv | 88 ++++++++
 rtl/pad_hit_capture.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pad_pkg.sv
// Shared constants and state encoding for the pad-mode hit capture block.
// Frame layout: BCID in the top 12 bits, pad hit map below it.
package pad_pkg;

   localparam int PAD_DATA_W   = 116;
   localparam int PAD_BCID_MSB = 115;
   localparam int PAD_BCID_LSB = 104;
   localparam int PAD_HIT_W    = 104;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } pad_state_e;

endpackage

// File: rtl/pad_sync_fifo.sv
// Single-clock frame FIFO: registered read with a 1-cycle rd_valid pulse,
// occupancy count, push/pop in the same cycle at any level, and a flush.
module pad_sync_fifo #(
   parameter int DATA_W = 116,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk160,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              pop_ok, push_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_L);
   assign count    = count_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   // When full, a push is only accepted if the same-cycle pop frees the slot.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & ~flush & (~full | pop_ok);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = pop_ok;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem[rd_ptr_q];
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk160) begin
      if (push_ok) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk160 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

endmodule

// File: rtl/pad_hit_capture.sv
// Armed capture of checker hit frames into a readout FIFO, plus free-running
// hit-frame and link-drop counters.
module pad_hit_capture
   import pad_pkg::*;
#(
   parameter int DATA_W = 116,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk160,
   input  logic              reset_n,
   input  logic              arm,
   input  logic [ADDR_W:0]   capture_len,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              linked,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              fifo_empty,
   output logic [ADDR_W:0]   fifo_count,
   output logic [1:0]        state,
   output logic              capture_done,
   output logic              overflow,
   output logic [CNT_W-1:0]  hit_frame_cnt,
   output logic [7:0]        link_drop_cnt
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   pad_state_e        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   captured_q, captured_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              linked_r_q;

   logic              wr, arm_ok, wr_room;
   logic              fifo_flush, fifo_push, fifo_full;

   assign wr      = data_valid & linked;
   assign arm_ok  = arm & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign wr_room = ~fifo_full | (rd_en & ~fifo_empty);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      captured_d = captured_q;
      overflow_d = overflow_q;
      fifo_flush = 1'b0;
      fifo_push  = 1'b0;
      if (arm_ok) begin
         fifo_flush = 1'b1;
         len_d      = (capture_len == '0 || capture_len > DEPTH_L) ? DEPTH_L : capture_len;
         captured_d = '0;
         overflow_d = 1'b0;
         state_d    = ST_ARMED;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (linked) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // A link drop pauses capture; progress is kept for the relink.
               if (!linked) begin
                  state_d = ST_ARMED;
               end else if (wr) begin
                  if (wr_room) begin
                     fifo_push  = 1'b1;
                     captured_d = captured_q + ONE_L;
                     if (captured_d == len_q) state_d = ST_DONE;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (wr && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if (linked_r_q && !linked && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk160 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         len_q      <= DEPTH_L;
         captured_q <= '0;
         overflow_q <= 1'b0;
         hit_cnt_q  <= '0;
         drop_cnt_q <= '0;
         linked_r_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         captured_q <= captured_d;
         overflow_q <= overflow_d;
         hit_cnt_q  <= hit_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         linked_r_q <= linked;
      end
   end

   pad_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk160   (clk160),
      .reset_n  (reset_n),
      .flush    (fifo_flush),
      .push     (fifo_push),
      .pop      (rd_en),
      .wr_data  (data_in),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   assign state         = state_q;
   assign capture_done  = (state_q == ST_DONE);
   assign overflow      = overflow_q;
   assign hit_frame_cnt = hit_cnt_q;
   assign link_drop_cnt = drop_cnt_q;

endmodule
